frame_bank_sched: RTL
=====================

Name: frame_bank_sched

Overview:
- Frame-level scheduler between the camera write path and the CNN read path of the double-banked input buffer.
- Owns bank selection: decides which bank the camera fills and which bank the CNN window reads.
- Starts one CNN frame pass per selected camera frame, never swaps a bank the CNN is still reading, and drops frames that arrive while the CNN is busy.
- Runs in the 100 MHz system domain; camera VSYNC enters asynchronously and is synchronised internally.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on iCamVsync (minimum 2).
- CNT_W, 16, width of frame and drop counters.

Ports:
- iClk  input  1  system clock, 100 MHz.
- iRsn  input  1  asynchronous active-low reset.
- iEnable  input  1  scheduler enable (from AXI-lite register bit).
- iSkipN  input  4  frame decimation: select 1 of every iSkipN+1 complete frames.
- iCamVsync  input  1  raw camera VSYNC, asynchronous; its rising edge marks end of frame.
- iCnnDone  input  1  single-cycle pulse from the CNN: frame pass finished, read bank released.
- oWrBank  output  1  bank index written by the camera.
- oRdBank  output  1  bank index read by the CNN; always equals ~oWrBank.
- oFrameStart  output  1  single-cycle pulse: CNN starts a pass on oRdBank.
- oBusy  output  1  high while a CNN pass is outstanding (state RUN).
- oFrameCnt  output  CNT_W  number of frames started; wraps.
- oDropCnt  output  CNT_W  selected frames dropped because the CNN was busy; saturates at all-ones.

Behaviour:
- Reset values: oWrBank=0, oRdBank=1, oFrameStart=0, oBusy=0, oFrameCnt=0, oDropCnt=0, skip counter=0, state=DIS, synchroniser flops=0.
- Vsync path:
  - SYNC_STAGES flops, then one history flop.
  - frame_edge = sync_out & ~history.
  - Default latency: iCamVsync first sampled high at edge k gives frame_edge during cycle k+2. Any resulting oFrameStart and bank toggle are registered at edge k+3.
- States:
  - DIS: idle. If iEnable=1, go to SYNC.
  - SYNC: waits for the first frame_edge; that frame is partial and discarded. On frame_edge, go to FILL. The skip counter is not touched.
  - FILL: the camera is filling oWrBank and the CNN is idle. On frame_edge, evaluate selection:
    - selected: toggle oWrBank/oRdBank, pulse oFrameStart, increment oFrameCnt, go to RUN.
    - unselected: stay in FILL.
  - RUN: a CNN pass is outstanding.
    - iCnnDone alone: go to FILL.
    - frame_edge alone: if selected, increment oDropCnt (saturating); banks untouched; stay in RUN. If unselected, no action.
    - iCnnDone and frame_edge in the same cycle: done is processed first. If selected, swap, pulse, increment oFrameCnt, stay in RUN. If unselected, go to FILL. No drop is counted.
- Selection: on every frame_edge in FILL or RUN:
  - selected = (skip_cnt == iSkipN).
  - skip_cnt <= selected ? 0 : skip_cnt+1.
  - With iSkipN=0, every frame is selected.
  - If iSkipN changes below skip_cnt, the counter wraps naturally at 4 bits and no special handling applies.
- iCnnDone in FILL, SYNC or DIS is ignored.
- iEnable=0 in any state: go to DIS at the next edge.
  - Banks, counters and skip_cnt hold.
  - An in-flight pass is abandoned and oBusy drops.
  - Re-enable restarts from SYNC, so the partial frame is again discarded.
- oFrameStart is never high for two consecutive cycles. Banks change only in the cycle oFrameStart is high.
- oBusy = (state==RUN), registered.
- Asynchronous reset mid-frame returns all of the above to reset values immediately.

Test Plan:
- Reset, iEnable=1, iSkipN=0, iCamVsync rises at cycles 100, 1000 and 2000, iCnnDone pulse at 500 → edge at 100 discarded; oFrameStart at 1003 with oWrBank 0→1; iCnnDone at 1500 returns the block to FILL; second start at 2003 with oWrBank→0; oFrameCnt=2, oDropCnt=0.
- CNN kept busy (no iCnnDone) across 3 further vsync edges after the first start → oDropCnt=3, oFrameCnt=1, oWrBank unchanged, oBusy=1 throughout.
- iSkipN=2, 9 complete frames with iCnnDone pulsed between every frame → oFrameStart only on frames 3, 6 and 9; oFrameCnt=3, oDropCnt=0.
- iCnnDone and frame_edge coincide in RUN with the frame selected → oFrameStart next cycle, banks swap, oBusy stays 1, oDropCnt unchanged.
- iEnable deasserted during RUN, then re-asserted → oBusy=0 next cycle; first vsync edge after re-enable produces no start; the second produces oFrameStart; counters retained.
- oDropCnt preloaded near saturation by forcing 65540 busy-frame drops → oDropCnt holds at 0xFFFF.

Source files
------------

// File: rtl/frame_bank_sched.sv
// Frame-level bank scheduler for the double-banked camera/CNN input buffer.
// Picks the camera write bank and CNN read bank, launches one CNN pass per selected frame.
module frame_bank_sched #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             iClk,
  input  logic             iRsn,
  input  logic             iEnable,
  input  logic [3:0]       iSkipN,
  input  logic             iCamVsync,
  input  logic             iCnnDone,
  output logic             oWrBank,
  output logic             oRdBank,
  output logic             oFrameStart,
  output logic             oBusy,
  output logic [CNT_W-1:0] oFrameCnt,
  output logic [CNT_W-1:0] oDropCnt,
  output logic [1:0]       oState
);

  // Handshake: oFrameStart is a one-cycle pulse launching a pass on oRdBank; the CNN
  // answers with a one-cycle iCnnDone pulse, which is honoured only while a pass is outstanding.

  typedef enum logic [1:0] {
    ST_DIS  = 2'd0,
    ST_SYNC = 2'd1,
    ST_FILL = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_q;
  logic                   wr_bank_q;
  logic                   frame_start_q;
  logic                   busy_q;
  logic [CNT_W-1:0]       frame_cnt_q;
  logic [CNT_W-1:0]       drop_cnt_q;
  logic [3:0]             skip_q;

  logic                   frame_edge;
  logic                   sel;
  logic [3:0]             skip_nxt;

  // The edge detect is registered, so FSM decisions land three edges after the
  // first high sample of the raw VSYNC.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], iCamVsync};
      hist_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  assign frame_edge = edge_q;

  // Decimation: take one frame, then skip iSkipN; the 4-bit counter simply wraps.
  always_comb begin
    sel      = (skip_q == iSkipN);
    skip_nxt = sel ? 4'd0 : skip_q + 4'd1;
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q       <= ST_DIS;
      wr_bank_q     <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= '0;
      drop_cnt_q    <= '0;
      skip_q        <= 4'd0;
    end else begin
      frame_start_q <= 1'b0;
      if (!iEnable) begin
        state_q <= ST_DIS;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_DIS: begin
            state_q <= ST_SYNC;
          end
          ST_SYNC: begin
            // First edge after enable closes a partial frame; it is discarded.
            if (frame_edge) begin
              state_q <= ST_FILL;
            end
          end
          ST_FILL: begin
            if (frame_edge) begin
              skip_q <= skip_nxt;
              if (sel) begin
                wr_bank_q     <= ~wr_bank_q;
                frame_start_q <= 1'b1;
                frame_cnt_q   <= frame_cnt_q + CNT_W'(1);
                state_q       <= ST_RUN;
                busy_q        <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (frame_edge) begin
              skip_q <= skip_nxt;
              if (sel && iCnnDone) begin
                // Read bank released this very cycle, so the new frame can go straight in.
                wr_bank_q     <= ~wr_bank_q;
                frame_start_q <= 1'b1;
                frame_cnt_q   <= frame_cnt_q + CNT_W'(1);
              end else if (sel) begin
                if (drop_cnt_q != {CNT_W{1'b1}}) begin
                  drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                end
              end else if (iCnnDone) begin
                state_q <= ST_FILL;
                busy_q  <= 1'b0;
              end
            end else if (iCnnDone) begin
              state_q <= ST_FILL;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_DIS;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oWrBank     = wr_bank_q;
  assign oRdBank     = ~wr_bank_q;
  assign oFrameStart = frame_start_q;
  assign oBusy       = busy_q;
  assign oFrameCnt   = frame_cnt_q;
  assign oDropCnt    = drop_cnt_q;
  assign oState      = state_q;

endmodule
